// File: rtl/nf_mem_port_arb_if.sv
// Handshake bundle for the nanoFOX memory port arbiter: fetch and load/store
// requester channels plus the shared memory port.
interface nf_mem_port_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          ls_req;
    logic          ls_we;
    logic [1:0]    ls_size;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wd;
    logic [DW-1:0] ls_rdata;
    logic          ls_ack;

    logic          mem_req;
    logic          mem_we;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wd,
               mem_rdata, mem_ack,
        output if_rdata, if_ack, ls_rdata, ls_ack,
               mem_req, mem_we, mem_size, mem_addr, mem_wd
    );

    // Core datapath plus memory view.
    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wd,
               mem_rdata, mem_ack,
        input  if_rdata, if_ack, ls_rdata, ls_ack,
               mem_req, mem_we, mem_size, mem_addr, mem_wd
    );
endinterface

// File: rtl/nf_mem_port_arb.sv
// Shares one memory port between instruction fetch and load/store. Data wins
// ties, but a starvation counter forces a fetch after STARVE_MAX data wins.
module nf_mem_port_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           resetn,
    nf_mem_port_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [1:0] SIZE_WORD  = 2'b10;

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Arbitration happens only in IDLE; a grant is held until mem_ack, even if
    // the requester misbehaves and drops its request early.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ls_req && bus.if_req) begin
                    if (starve_q < STARVE_LIM) begin
                        state_d  = LS_BUSY;
                        starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
                    end else begin
                        state_d  = IF_BUSY;
                        starve_d = 4'd0;
                    end
                end else if (bus.ls_req) begin
                    state_d = LS_BUSY;
                end else if (bus.if_req) begin
                    state_d  = IF_BUSY;
                    starve_d = 4'd0;
                end
            end
            IF_BUSY, LS_BUSY: begin
                if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode purely from the registered state, so reset forces the
    // idle values without waiting for a clock.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_size = SIZE_WORD;
        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        bus.if_ack   = 1'b0;
        bus.if_rdata = '0;
        bus.ls_ack   = 1'b0;
        bus.ls_rdata = '0;
        unique case (state_q)
            IF_BUSY: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.if_addr;
                bus.if_ack   = bus.mem_ack;
                bus.if_rdata = bus.mem_rdata;
            end
            LS_BUSY: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = bus.ls_we;
                bus.mem_size = bus.ls_size;
                bus.mem_addr = bus.ls_addr;
                bus.mem_wd   = bus.ls_wd;
                bus.ls_ack   = bus.mem_ack;
                bus.ls_rdata = bus.mem_rdata;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_nf_mem_port_arb.sv
// Directed bench for nf_mem_port_arb: reset, fetch, store, priority,
// starvation and spurious/illegal handshake cases.
module tb_nf_mem_port_arb;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic auto_ack = 1'b0;
    logic man_ack = 1'b0;
    int   checks = 0;
    int   failures = 0;

    nf_mem_port_arb_if #(.AW(32), .DW(32)) bus ();

    nf_mem_port_arb #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Zero-wait memory model when auto_ack is set, manual ack otherwise.
    assign bus.mem_ack = auto_ack ? bus.mem_req : man_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_req    = 1'b0;
        bus.ls_we     = 1'b0;
        bus.ls_size   = 2'b00;
        bus.ls_addr   = '0;
        bus.ls_wd     = '0;
        bus.mem_rdata = '0;

        // Reset values
        #2;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_size", 32'(bus.mem_size), 32'd2);
        chk("rst_acks", 32'({bus.if_ack, bus.ls_ack}), 32'd0);
        step();
        resetn = 1'b1;
        step();

        // Single fetch, memory acks 3 cycles after mem_req
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        step();
        mid();
        chk("if_mem_req", 32'(bus.mem_req), 32'd1);
        chk("if_mem_size", 32'(bus.mem_size), 32'd2);
        chk("if_mem_we", 32'(bus.mem_we), 32'd0);
        chk("if_mem_addr", bus.mem_addr, 32'h10);
        chk("if_ack_early", 32'(bus.if_ack), 32'd0);
        step();
        mid();
        chk("if_hold1", 32'(bus.mem_req), 32'd1);
        step();
        mid();
        chk("if_hold2", 32'(bus.mem_req), 32'd1);
        step();
        man_ack       = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        mid();
        chk("if_ack", 32'(bus.if_ack), 32'd1);
        chk("if_rdata", bus.if_rdata, 32'h0050_0093);
        chk("if_ls_ack0", 32'(bus.ls_ack), 32'd0);
        step();
        man_ack    = 1'b0;
        bus.if_req = 1'b0;
        mid();
        chk("if_idle_req", 32'(bus.mem_req), 32'd0);
        chk("if_idle_ack", 32'(bus.if_ack), 32'd0);
        step();

        // Store pass-through, zero-wait memory
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b1;
        bus.ls_size = 2'b00;
        bus.ls_addr = 32'h0000_0104;
        bus.ls_wd   = 32'h0000_00AB;
        step();
        man_ack = 1'b1;
        mid();
        chk("st_mem_req", 32'(bus.mem_req), 32'd1);
        chk("st_mem_we", 32'(bus.mem_we), 32'd1);
        chk("st_mem_size", 32'(bus.mem_size), 32'd0);
        chk("st_mem_addr", bus.mem_addr, 32'h104);
        chk("st_mem_wd", bus.mem_wd, 32'hAB);
        chk("st_ls_ack", 32'(bus.ls_ack), 32'd1);
        chk("st_if_ack0", 32'(bus.if_ack), 32'd0);
        step();
        man_ack    = 1'b0;
        bus.ls_req = 1'b0;
        bus.ls_we  = 1'b0;
        mid();
        chk("st_idle_req", 32'(bus.mem_req), 32'd0);
        step();

        // Priority: simultaneous requests, load/store first
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0200;
        bus.ls_req  = 1'b1;
        bus.ls_size = 2'b10;
        bus.ls_addr = 32'h0000_0300;
        step();
        man_ack       = 1'b1;
        bus.mem_rdata = 32'hCAFE_0001;
        mid();
        chk("pri_first_addr", bus.mem_addr, 32'h300);
        chk("pri_first_acks", 32'({bus.if_ack, bus.ls_ack}), 32'd1);
        chk("pri_ls_rdata", bus.ls_rdata, 32'hCAFE_0001);
        step();
        man_ack    = 1'b0;
        bus.ls_req = 1'b0;
        mid();
        chk("pri_idle_req", 32'(bus.mem_req), 32'd0);
        step();
        man_ack = 1'b1;
        mid();
        chk("pri_second_addr", bus.mem_addr, 32'h200);
        chk("pri_second_acks", 32'({bus.if_ack, bus.ls_ack}), 32'd2);
        step();
        man_ack    = 1'b0;
        bus.if_req = 1'b0;
        step();

        // Starvation: both held, zero-wait memory -> 4 ls, 1 fetch, repeat
        auto_ack   = 1'b1;
        bus.if_req = 1'b1;
        bus.ls_req = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            mid();
            chk($sformatf("starve_grant%0d", t), 32'({bus.if_ack, bus.ls_ack}),
                (t % 5 == 4) ? 32'd2 : 32'd1);
            if (t % 5 == 4) chk("starve_clr", 32'(dut.starve_q), 32'd0);
            step();
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        auto_ack   = 1'b0;
        step();

        // Spurious ack in IDLE
        man_ack = 1'b1;
        mid();
        chk("spur_acks", 32'({bus.if_ack, bus.ls_ack}), 32'd0);
        chk("spur_req", 32'(bus.mem_req), 32'd0);
        step();
        man_ack = 1'b0;
        mid();
        chk("spur_stay_idle", 32'(bus.mem_req), 32'd0);
        step();

        // Illegal drop of if_req mid-transaction: grant held until mem_ack
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0044;
        step();
        bus.if_req = 1'b0;
        mid();
        chk("drop_req0", 32'(bus.mem_req), 32'd1);
        step();
        mid();
        chk("drop_req1", 32'(bus.mem_req), 32'd1);
        step();
        man_ack = 1'b1;
        mid();
        chk("drop_ack", 32'(bus.if_ack), 32'd1);
        step();
        man_ack = 1'b0;
        mid();
        chk("drop_idle", 32'(bus.mem_req), 32'd0);
        step();

        // Asynchronous reset in LS_BUSY with no mem_ack
        bus.ls_req = 1'b1;
        bus.ls_we  = 1'b0;
        step();
        mid();
        chk("rst_busy_req", 32'(bus.mem_req), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_req", 32'(bus.mem_req), 32'd0);
        chk("rst_async_acks", 32'({bus.if_ack, bus.ls_ack}), 32'd0);
        bus.ls_req = 1'b0;
        step();
        resetn = 1'b1;
        step();
        mid();
        chk("rst_after_req", 32'(bus.mem_req), 32'd0);
        chk("rst_after_acks", 32'({bus.if_ack, bus.ls_ack}), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
